// File: rtl/rotate_tick_gen_pkg.sv
// Shared constants and helpers for the rotation tick generator.
// Direction encoding and a width function usable in parameter expressions.
package rotate_tick_gen_pkg;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    // Minimum index width for n values; never returns less than 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((64'd1 << w) < 64'(n)) begin
            w = w + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/rotate_pos_ctr.sv
// Rotating position index 0..POS_N-1 with direction select.
// Steps once per i_step; o_wrap pulses on the step that wraps the index.
module rotate_pos_ctr
    import rotate_tick_gen_pkg::*;
#(
    parameter int unsigned POS_N = 4,
    localparam int unsigned POS_W = clog2(POS_N)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_step,
    input  logic             i_dir,
    output logic [POS_W-1:0] o_pos,
    output logic             o_wrap
);

    localparam logic [POS_W-1:0] PosLast = POS_W'(POS_N - 1);

    logic [POS_W-1:0] r_pos;
    logic             r_wrap;
    logic [POS_W-1:0] w_pos_nxt;
    logic             w_wrap_nxt;

    always_comb begin
        w_pos_nxt  = r_pos;
        w_wrap_nxt = 1'b0;
        if (i_step) begin
            unique case (i_dir)
                DIR_FWD: begin
                    if (r_pos == PosLast) begin
                        w_pos_nxt  = '0;
                        w_wrap_nxt = 1'b1;
                    end else begin
                        w_pos_nxt = r_pos + POS_W'(1);
                    end
                end
                DIR_REV: begin
                    if (r_pos == '0) begin
                        w_pos_nxt  = PosLast;
                        w_wrap_nxt = 1'b1;
                    end else begin
                        w_pos_nxt = r_pos - POS_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_pos  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_pos  <= w_pos_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign o_pos  = r_pos;
    assign o_wrap = r_wrap;

endmodule

// File: rtl/rotate_tick_gen.sv
// Programmable rate generator: tick enable, derived square wave and rotating index.
// A loaded divider value is held in a shadow and only applied at a period boundary.
module rotate_tick_gen
    import rotate_tick_gen_pkg::*;
#(
    parameter int unsigned      CNT_W     = 22,
    parameter logic [CNT_W-1:0] DIV_RESET = 22'h3FFFFF,
    parameter int unsigned      POS_N     = 4,
    localparam int unsigned     POS_W     = clog2(POS_N)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_div_load,
    input  logic [CNT_W-1:0] i_div_val,
    input  logic             i_dir,
    output logic             o_tick,
    output logic             o_slow_clk,
    output logic [POS_W-1:0] o_pos,
    output logic             o_wrap,
    output logic             o_div_busy
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_shadow;
    logic             r_busy;
    logic             r_tick;
    logic             r_slow;

    logic [CNT_W-1:0] w_count_nxt;
    logic [CNT_W-1:0] w_div_nxt;
    logic [CNT_W-1:0] w_shadow_nxt;
    logic             w_busy_nxt;
    logic             w_slow_nxt;
    logic             w_terminal;

    // Divider only changes here, so the counter can never overshoot it.
    assign w_terminal = i_en && (r_count == r_div);

    always_comb begin
        w_count_nxt  = r_count;
        w_div_nxt    = r_div;
        w_shadow_nxt = r_shadow;
        w_busy_nxt   = r_busy;
        w_slow_nxt   = r_slow;
        if (w_terminal) begin
            w_count_nxt = '0;
            w_slow_nxt  = ~r_slow;
            if (i_div_load) begin
                w_div_nxt  = i_div_val;
                w_busy_nxt = 1'b0;
            end else if (r_busy) begin
                w_div_nxt  = r_shadow;
                w_busy_nxt = 1'b0;
            end
        end else begin
            if (i_en) begin
                w_count_nxt = r_count + CNT_W'(1);
            end
            if (i_div_load) begin
                w_shadow_nxt = i_div_val;
                w_busy_nxt   = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_count  <= '0;
            r_div    <= DIV_RESET;
            r_shadow <= '0;
            r_busy   <= 1'b0;
            r_tick   <= 1'b0;
            r_slow   <= 1'b0;
        end else begin
            r_count  <= w_count_nxt;
            r_div    <= w_div_nxt;
            r_shadow <= w_shadow_nxt;
            r_busy   <= w_busy_nxt;
            r_tick   <= w_terminal;
            r_slow   <= w_slow_nxt;
        end
    end

    rotate_pos_ctr #(
        .POS_N (POS_N)
    ) u_pos_ctr (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_step (w_terminal),
        .i_dir  (i_dir),
        .o_pos  (o_pos),
        .o_wrap (o_wrap)
    );

    assign o_tick     = r_tick;
    assign o_slow_clk = r_slow;
    assign o_div_busy = r_busy;

endmodule

// File: tb/tb_rotate_tick_gen.sv
// Bench for rotate_tick_gen: directed literal sequences plus randomized traffic,
// every cycle checked against a period/queue-level behavioural model.
module tb_rotate_tick_gen;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned POS_N = 3;
    localparam int          DIV_RST = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       div_load;
    logic [3:0] div_val;
    logic       dir;
    logic       tick;
    logic       slow_clk;
    logic [1:0] pos;
    logic       wrap;
    logic       div_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rotate_tick_gen #(
        .CNT_W     (CNT_W),
        .DIV_RESET (4'd3),
        .POS_N     (POS_N)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_div_load (div_load),
        .i_div_val  (div_val),
        .i_dir      (dir),
        .o_tick     (tick),
        .o_slow_clk (slow_clk),
        .o_pos      (pos),
        .o_wrap     (wrap),
        .o_div_busy (div_busy)
    );

    // Model: elapsed count within the period, period length, pending divider (-1 = none).
    int m_count  = 0;
    int m_div    = DIV_RST;
    int m_pend   = -1;
    int m_pos    = 0;
    bit m_tick   = 0;
    bit m_slow   = 0;
    bit m_wrap   = 0;
    bit m_valid  = 0;
    bit m_term;

    function automatic int next_pos(input int p, input bit d);
        return d ? (p + POS_N - 1) % POS_N : (p + 1) % POS_N;
    endfunction

    assign m_term = en && (m_count == m_div);

    always @(posedge clk) begin
        if (!rst) begin
            m_count <= 0;
            m_div   <= DIV_RST;
            m_pend  <= -1;
            m_pos   <= 0;
            m_tick  <= 0;
            m_slow  <= 0;
            m_wrap  <= 0;
            m_valid <= 1;
        end else begin
            m_tick <= m_term;
            m_wrap <= m_term && (dir ? next_pos(m_pos, dir) > m_pos
                                     : next_pos(m_pos, dir) < m_pos);
            if (m_term) begin
                m_count <= 0;
                m_slow  <= !m_slow;
                m_pos   <= next_pos(m_pos, dir);
                m_div   <= div_load ? int'(div_val) : (m_pend >= 0 ? m_pend : m_div);
                m_pend  <= -1;
            end else begin
                if (en) m_count <= m_count + 1;
                if (div_load) m_pend <= int'(div_val);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_tick", 32'(tick), 32'(m_tick));
            chk("model_wrap", 32'(wrap), 32'(m_wrap));
            chk("model_busy", 32'(div_busy), 32'(m_pend >= 0));
            chk("model_slow", 32'(slow_clk), 32'(m_slow));
            chk("model_pos", 32'(pos), 32'(m_pos));
        end
    end

    // Advance one clock edge and compare outputs with hand-computed literals.
    task automatic edge_chk(input string nm, input logic t, input logic w, input logic b,
                            input logic s, input int p);
        @(negedge clk);
        chk({nm, "_tick"}, 32'(tick), 32'(t));
        chk({nm, "_wrap"}, 32'(wrap), 32'(w));
        chk({nm, "_busy"}, 32'(div_busy), 32'(b));
        chk({nm, "_slow"}, 32'(slow_clk), 32'(s));
        chk({nm, "_pos"}, 32'(pos), 32'(p));
    endtask

    int s1_pos[12]  = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 0};
    int s2_pos[12]  = '{0, 0, 0, 2, 2, 2, 2, 1, 1, 1, 1, 0};
    bit s_slow[12]  = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1};

    initial begin
        rst = 1'b0; en = 1'b0; dir = 1'b0; div_load = 1'b0; div_val = '0;

        // Reset state, then forward rotation at the reset period of 4.
        edge_chk("rst0", 0, 0, 0, 0, 0);
        edge_chk("rst1", 0, 0, 0, 0, 0);
        rst = 1'b1; en = 1'b1;
        for (int i = 0; i < 12; i++)
            edge_chk("fwd", (i % 4) == 3, i == 11, 0, s_slow[i], s1_pos[i]);

        // Reverse rotation wraps on the first tick.
        rst = 1'b0; dir = 1'b1;
        edge_chk("rst2", 0, 0, 0, 0, 0);
        rst = 1'b1;
        for (int i = 0; i < 12; i++)
            edge_chk("rev", (i % 4) == 3, i == 3, 0, s_slow[i], s2_pos[i]);

        // Shadowed load mid-period, then a zero divider.
        rst = 1'b0; dir = 1'b0;
        edge_chk("rst3", 0, 0, 0, 0, 0);
        rst = 1'b1;
        edge_chk("ld_e1", 0, 0, 0, 0, 0);
        div_load = 1'b1; div_val = 4'd1;
        edge_chk("ld_e2", 0, 0, 1, 0, 0);
        div_load = 1'b0;
        edge_chk("ld_e3", 0, 0, 1, 0, 0);
        edge_chk("ld_e4", 1, 0, 0, 1, 1);
        edge_chk("ld_e5", 0, 0, 0, 1, 1);
        edge_chk("ld_e6", 1, 0, 0, 0, 2);
        edge_chk("ld_e7", 0, 0, 0, 0, 2);
        edge_chk("ld_e8", 1, 1, 0, 1, 0);
        div_load = 1'b1; div_val = 4'd0;
        edge_chk("z_e9", 0, 0, 1, 1, 0);
        div_load = 1'b0;
        edge_chk("z_e10", 1, 0, 0, 0, 1);
        edge_chk("z_e11", 1, 0, 0, 1, 2);
        edge_chk("z_e12", 1, 1, 0, 0, 0);

        // Reset while a load is pending restores the reset divider.
        rst = 1'b0;
        edge_chk("rst4", 0, 0, 0, 0, 0);
        rst = 1'b1;
        edge_chk("pr_e1", 0, 0, 0, 0, 0);
        edge_chk("pr_e2", 0, 0, 0, 0, 0);
        div_load = 1'b1; div_val = 4'd1;
        edge_chk("pr_e3", 0, 0, 1, 0, 0);
        div_load = 1'b0; rst = 1'b0;
        edge_chk("pr_rst", 0, 0, 0, 0, 0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++)
            edge_chk("pr_per", i == 3, 0, 0, i == 3, (i == 3) ? 1 : 0);

        // Freeze with en=0 at count 2.
        edge_chk("fz_e1", 0, 0, 0, 1, 1);
        edge_chk("fz_e2", 0, 0, 0, 1, 1);
        en = 1'b0;
        for (int i = 0; i < 5; i++)
            edge_chk("fz_hold", 0, 0, 0, 1, 1);
        en = 1'b1;
        edge_chk("fz_r1", 0, 0, 0, 1, 1);
        edge_chk("fz_r2", 1, 0, 0, 0, 2);

        // Randomized traffic checked by the model only.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst      = ($urandom_range(0, 299) != 0);
            en       = ($urandom_range(0, 7) != 0);
            dir      = 1'($urandom_range(0, 1));
            div_load = ($urandom_range(0, 15) == 0);
            div_val  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                   : 4'($urandom_range(0, 4));
        end
        @(negedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
